rr_grant_arbiter: RTL and testbench

Round-robin arbiter sharing one resource among `N_REQ` requesters using a request / grant / revoke / release handshake. It is the sequencing controller that sits in front of each per-requester IDLE→REQUESTING→GRANT→REVOKE client FSM. It issues at most one grant at a time and preempts a holder after a bounded tenure when other requesters are waiting.

---
 rtl/arbiter_pkg.sv | 26 ++
 rtl/rr_priority_pick.sv | 39 +++
 rtl/rr_grant_arbiter.sv | 155 +++++++++++++++
 tb/tb_rr_grant_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter_pkg
//  Description : Shared types and constants for the round-robin grant arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package arbiter_pkg;

    // Arbiter control states; encoding 2'b11 is unused and treated as illegal.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_GRANT  = 2'b01,
        ARB_REVOKE = 2'b10
    } ty_ARB_STATE;

    // Smallest legal grant tenure and requester count.
    localparam int unsigned C_MIN_TIMEOUT = 2;
    localparam int unsigned C_MIN_N_REQ   = 2;

    // Increment an index modulo n (used for the round-robin pointer).
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_pick
//  Description : Combinational rotating-priority picker. Finds the first set
//                request bit searching upward from the pointer, wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_onehot,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic                     o_valid
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] w_pos;

    // Walk the requesters starting at the pointer; the first hit wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_pos    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = IW'((int'(i_ptr) + k) % N_REQ);
            if (!o_valid && i_req[w_pos]) begin
                o_valid         = 1'b1;
                o_idx           = w_pos;
                o_onehot[w_pos] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_arbiter
//  Description : Round-robin arbiter with request/grant/revoke/release
//                handshake. One grant at a time; a holder is asked to give up
//                the resource after TIMEOUT_CYCLES when others are waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter
    import arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     i_ck,
    input  logic                     i_arst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_release,
    input  logic [N_REQ-1:0]         i_revokeAck,
    output logic [N_REQ-1:0]         o_grant,
    output logic [N_REQ-1:0]         o_revoke,
    output logic                     o_busy,
    output logic [$clog2(N_REQ)-1:0] o_grantId
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] C_CNT_SAT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] C_CNT_REV = CW'(TIMEOUT_CYCLES - 1);

    if (N_REQ < int'(C_MIN_N_REQ)) begin : g_bad_n_req
        $error("rr_grant_arbiter: N_REQ must be at least 2");
    end
    if (TIMEOUT_CYCLES < int'(C_MIN_TIMEOUT)) begin : g_bad_timeout
        $error("rr_grant_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    ty_ARB_STATE    state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] revoke_q, revoke_d;
    logic             busy_q, busy_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [N_REQ-1:0] w_pick_onehot;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic             w_holder_rel;
    logic             w_holder_ack;
    logic             w_others_waiting;
    logic [IW-1:0]    w_next_ptr;
    logic [CW-1:0]    w_cnt_inc;

    rr_priority_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req    (i_req),
        .i_ptr    (ptr_q),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // Holder-qualified handshake inputs; pulses from non-holders are ignored.
    always_comb begin
        w_holder_rel     = i_release[grant_id_q];
        w_holder_ack     = i_revokeAck[grant_id_q];
        w_others_waiting = |(i_req & ~grant_q);
        w_next_ptr       = IW'(wrap_inc(int'(grant_id_q), N_REQ));
        w_cnt_inc        = (cnt_q == C_CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        revoke_d   = revoke_q;
        busy_d     = busy_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    state_d    = ARB_GRANT;
                    grant_d    = w_pick_onehot;
                    grant_id_d = w_pick_idx;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                end
            end
            ARB_GRANT: begin
                cnt_d = w_cnt_inc;
                if (w_holder_rel) begin
                    // Release beats a coincident timeout.
                    state_d  = ARB_IDLE;
                    grant_d  = '0;
                    revoke_d = '0;
                    busy_d   = 1'b0;
                    ptr_d    = w_next_ptr;
                end else if (w_others_waiting && (cnt_q >= C_CNT_REV)) begin
                    // Tenure expired (or already saturated) with a waiter.
                    state_d  = ARB_REVOKE;
                    revoke_d = grant_q;
                end
            end
            ARB_REVOKE: begin
                if (w_holder_rel || w_holder_ack) begin
                    state_d  = ARB_IDLE;
                    grant_d  = '0;
                    revoke_d = '0;
                    busy_d   = 1'b0;
                    ptr_d    = w_next_ptr;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                grant_d  = '0;
                revoke_d = '0;
                busy_d   = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // State, pointer, counter and output registers with asynchronous reset.
    always_ff @(posedge i_ck or posedge i_arst) begin
        if (i_arst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            revoke_q   <= '0;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            revoke_q   <= revoke_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_revoke  = revoke_q;
    assign o_busy    = busy_q;
    assign o_grantId = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_grant_arbiter
//  Description : Self-checking bench for rr_grant_arbiter (N_REQ=4,
//                TIMEOUT_CYCLES=4) using an expected-output queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;

    localparam int N = 4;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       arst;
    logic [3:0] req, rel, ack;
    logic [3:0] grant, revoke;
    logic       busy;
    logic [1:0] gid;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] r;
        logic       b;
        logic [1:0] id;
    } exp_t;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] rel;
        logic [3:0] ack;
        exp_t       e;
    } row_t;

    exp_t exp_q[$];
    row_t rq[$];
    exp_t act, ex;
    int   checks   = 0;
    int   failures = 0;

    rr_grant_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_ck        (clk),
        .i_arst      (arst),
        .i_req       (req),
        .i_release   (rel),
        .i_revokeAck (ack),
        .o_grant     (grant),
        .o_revoke    (revoke),
        .o_busy      (busy),
        .o_grantId   (gid)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] g, input logic [3:0] r,
                                input logic b, input logic [1:0] id);
        exp_t e;
        e.g = g; e.r = r; e.b = b; e.id = id;
        return e;
    endfunction

    function automatic row_t rw(input logic [3:0] rq_v, input logic [3:0] rl,
                                input logic [3:0] ak, input exp_t e);
        row_t r;
        r.req = rq_v; r.rel = rl; r.ack = ak; r.e = e;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1; req = '0; rel = '0; ack = '0;
        repeat (2) cyc();
        exp_q.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0));
        act = {grant, revoke, busy, gid};
        ex  = exp_q.pop_front();
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL reset: got g=%b r=%b b=%b id=%0d, expected g=%b r=%b b=%b id=%0d",
                     act.g, act.r, act.b, act.id, ex.g, ex.r, ex.b, ex.id);
        end
        #2 arst = 1'b0;
        exp_q.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0));
        cyc();
        act = {grant, revoke, busy, gid};
        ex  = exp_q.pop_front();
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL reset_idle: got g=%b r=%b b=%b id=%0d, expected g=%b r=%b b=%b id=%0d",
                     act.g, act.r, act.b, act.id, ex.g, ex.r, ex.b, ex.id);
        end
    endtask

    task automatic test_basic_grant();
        rq = {};
        rq.push_back(rw(4'b0100, 4'b0000, 4'b0000, mk(4'b0100, 4'b0000, 1'b1, 2'd2)));
        rq.push_back(rw(4'b0100, 4'b0000, 4'b0000, mk(4'b0100, 4'b0000, 1'b1, 2'd2)));
        rq.push_back(rw(4'b0100, 4'b0100, 4'b0000, mk(4'b0000, 4'b0000, 1'b0, 2'd2)));
        rq.push_back(rw(4'b0000, 4'b0000, 4'b0000, mk(4'b0000, 4'b0000, 1'b0, 2'd2)));
        rq.push_back(rw(4'b1001, 4'b0000, 4'b0000, mk(4'b1000, 4'b0000, 1'b1, 2'd3)));
        rq.push_back(rw(4'b0000, 4'b1000, 4'b0000, mk(4'b0000, 4'b0000, 1'b0, 2'd3)));
        foreach (rq[i]) begin
            req = rq[i].req; rel = rq[i].rel; ack = rq[i].ack;
            exp_q.push_back(rq[i].e);
            cyc();
            act = {grant, revoke, busy, gid};
            ex  = exp_q.pop_front();
            checks++;
            if (act !== ex) begin
                failures++;
                $display("FAIL basic_grant step %0d: got g=%b r=%b b=%b id=%0d, expected g=%b r=%b b=%b id=%0d",
                         i, act.g, act.r, act.b, act.id, ex.g, ex.r, ex.b, ex.id);
            end
        end
        rel = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0] h1;
        rq = {};
        for (int k = 0; k < 5; k++) begin
            h1 = 4'b0001 << (k % N);
            for (int j = 0; j < 3; j++)
                rq.push_back(rw(4'b1111, 4'b0000, 4'b0000, mk(h1, 4'b0000, 1'b1, 2'(k % N))));
            rq.push_back(rw(4'b1111, h1, 4'b0000, mk(4'b0000, 4'b0000, 1'b0, 2'(k % N))));
        end
        rq.push_back(rw(4'b0000, 4'b0000, 4'b0000, mk(4'b0000, 4'b0000, 1'b0, 2'd0)));
        foreach (rq[i]) begin
            req = rq[i].req; rel = rq[i].rel; ack = rq[i].ack;
            exp_q.push_back(rq[i].e);
            cyc();
            act = {grant, revoke, busy, gid};
            ex  = exp_q.pop_front();
            checks++;
            if (act !== ex) begin
                failures++;
                $display("FAIL round_robin step %0d: got g=%b r=%b b=%b id=%0d, expected g=%b r=%b b=%b id=%0d",
                         i, act.g, act.r, act.b, act.id, ex.g, ex.r, ex.b, ex.id);
            end
        end
    endtask

    task automatic test_revoke();
        arst = 1'b1;
        #2 arst = 1'b0;
        rq = {};
        rq.push_back(rw(4'b0011, 4'b0000, 4'b0000, mk(4'b0001, 4'b0000, 1'b1, 2'd0)));
        for (int j = 0; j < 3; j++)
            rq.push_back(rw(4'b0011, 4'b0000, 4'b0000, mk(4'b0001, 4'b0000, 1'b1, 2'd0)));
        rq.push_back(rw(4'b0011, 4'b0000, 4'b0000, mk(4'b0001, 4'b0001, 1'b1, 2'd0)));
        for (int j = 0; j < 10; j++)
            rq.push_back(rw(4'b0011, (j == 3) ? 4'b1110 : 4'b0000, (j == 5) ? 4'b1110 : 4'b0000,
                            mk(4'b0001, 4'b0001, 1'b1, 2'd0)));
        rq.push_back(rw(4'b0011, 4'b0000, 4'b0001, mk(4'b0000, 4'b0000, 1'b0, 2'd0)));
        rq.push_back(rw(4'b0011, 4'b0000, 4'b0000, mk(4'b0010, 4'b0000, 1'b1, 2'd1)));
        rq.push_back(rw(4'b0000, 4'b0010, 4'b0000, mk(4'b0000, 4'b0000, 1'b0, 2'd1)));
        foreach (rq[i]) begin
            req = rq[i].req; rel = rq[i].rel; ack = rq[i].ack;
            exp_q.push_back(rq[i].e);
            cyc();
            act = {grant, revoke, busy, gid};
            ex  = exp_q.pop_front();
            checks++;
            if (act !== ex) begin
                failures++;
                $display("FAIL revoke step %0d: got g=%b r=%b b=%b id=%0d, expected g=%b r=%b b=%b id=%0d",
                         i, act.g, act.r, act.b, act.id, ex.g, ex.r, ex.b, ex.id);
            end
        end
        rel = '0; ack = '0;
    endtask

    task automatic test_sole_holder();
        rq = {};
        for (int j = 0; j < 100; j++)
            rq.push_back(rw(4'b1000, 4'b0000, 4'b0000, mk(4'b1000, 4'b0000, 1'b1, 2'd3)));
        rq.push_back(rw(4'b1001, 4'b0000, 4'b0000, mk(4'b1000, 4'b1000, 1'b1, 2'd3)));
        rq.push_back(rw(4'b1001, 4'b1000, 4'b1000, mk(4'b0000, 4'b0000, 1'b0, 2'd3)));
        rq.push_back(rw(4'b0000, 4'b0000, 4'b0000, mk(4'b0000, 4'b0000, 1'b0, 2'd3)));
        foreach (rq[i]) begin
            req = rq[i].req; rel = rq[i].rel; ack = rq[i].ack;
            exp_q.push_back(rq[i].e);
            cyc();
            act = {grant, revoke, busy, gid};
            ex  = exp_q.pop_front();
            checks++;
            if (act !== ex) begin
                failures++;
                $display("FAIL sole_holder step %0d: got g=%b r=%b b=%b id=%0d, expected g=%b r=%b b=%b id=%0d",
                         i, act.g, act.r, act.b, act.id, ex.g, ex.r, ex.b, ex.id);
            end
        end
    endtask

    task automatic test_release_at_timeout();
        rq = {};
        rq.push_back(rw(4'b0011, 4'b0000, 4'b0000, mk(4'b0001, 4'b0000, 1'b1, 2'd0)));
        rq.push_back(rw(4'b0011, 4'b0010, 4'b0100, mk(4'b0001, 4'b0000, 1'b1, 2'd0)));
        rq.push_back(rw(4'b0011, 4'b0000, 4'b0000, mk(4'b0001, 4'b0000, 1'b1, 2'd0)));
        rq.push_back(rw(4'b0011, 4'b0000, 4'b0000, mk(4'b0001, 4'b0000, 1'b1, 2'd0)));
        rq.push_back(rw(4'b0011, 4'b0001, 4'b0000, mk(4'b0000, 4'b0000, 1'b0, 2'd0)));
        rq.push_back(rw(4'b0011, 4'b0000, 4'b0000, mk(4'b0010, 4'b0000, 1'b1, 2'd1)));
        rq.push_back(rw(4'b0000, 4'b0010, 4'b0000, mk(4'b0000, 4'b0000, 1'b0, 2'd1)));
        foreach (rq[i]) begin
            req = rq[i].req; rel = rq[i].rel; ack = rq[i].ack;
            exp_q.push_back(rq[i].e);
            cyc();
            act = {grant, revoke, busy, gid};
            ex  = exp_q.pop_front();
            checks++;
            if (act !== ex) begin
                failures++;
                $display("FAIL release_at_timeout step %0d: got g=%b r=%b b=%b id=%0d, expected g=%b r=%b b=%b id=%0d",
                         i, act.g, act.r, act.b, act.id, ex.g, ex.r, ex.b, ex.id);
            end
        end
        rel = '0; ack = '0;
    endtask

    task automatic test_async_reset();
        rq = {};
        for (int j = 0; j < 4; j++)
            rq.push_back(rw(4'b0101, 4'b0000, 4'b0000, mk(4'b0100, 4'b0000, 1'b1, 2'd2)));
        rq.push_back(rw(4'b0101, 4'b0000, 4'b0000, mk(4'b0100, 4'b0100, 1'b1, 2'd2)));
        foreach (rq[i]) begin
            req = rq[i].req; rel = rq[i].rel; ack = rq[i].ack;
            exp_q.push_back(rq[i].e);
            cyc();
            act = {grant, revoke, busy, gid};
            ex  = exp_q.pop_front();
            checks++;
            if (act !== ex) begin
                failures++;
                $display("FAIL async_reset setup %0d: got g=%b r=%b b=%b id=%0d, expected g=%b r=%b b=%b id=%0d",
                         i, act.g, act.r, act.b, act.id, ex.g, ex.r, ex.b, ex.id);
            end
        end
        // Reset lands mid-cycle; outputs must clear without a clock edge.
        #3 arst = 1'b1;
        exp_q.push_back(mk(4'b0000, 4'b0000, 1'b0, 2'd0));
        #1;
        act = {grant, revoke, busy, gid};
        ex  = exp_q.pop_front();
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL async_reset_clear: got g=%b r=%b b=%b id=%0d, expected g=%b r=%b b=%b id=%0d",
                     act.g, act.r, act.b, act.id, ex.g, ex.r, ex.b, ex.id);
        end
        #2 arst = 1'b0;
        req = 4'b1010;
        exp_q.push_back(mk(4'b0010, 4'b0000, 1'b1, 2'd1));
        cyc();
        act = {grant, revoke, busy, gid};
        ex  = exp_q.pop_front();
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL async_reset_ptr: got g=%b r=%b b=%b id=%0d, expected g=%b r=%b b=%b id=%0d",
                     act.g, act.r, act.b, act.id, ex.g, ex.r, ex.b, ex.id);
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_round_robin();
        test_revoke();
        test_sole_holder();
        test_release_at_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
